io_input_port: RTL and testbench
================================

Name: io_input_port

Overview:
- Memory-mapped input peripheral for the 5-stage core. It is the read-side counterpart of the Memory stage's LEDR/LEDG/HEX output drivers.
- Synchronizes and debounces board switches SW[9:0] and push-buttons KEY[3:0].
- Latches sticky key-press events.
- Returns register contents to the Memory stage on load requests, with one-cycle latency.
- Runs on the divided core clock, alongside Fetch/Decode/Execute/Memory/Writeback.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized input must differ from its stable value before the change is accepted. Legal range is 2 or more.
- DATA_WIDTH, 16, read-data width; matches REG_WIDTH.
- ADDR_SW, 16'hF010, address of the switch register.
- ADDR_KEY, 16'hF020, address of the debounced key-level register.
- ADDR_KEYEVT, 16'hF030, address of the sticky key-event register (clear-on-read).

Ports:
- I_CLOCK  input  1  core clock.
- I_RESET  input  1  asynchronous, active-high reset.
- I_SW  input  10  raw slide switches, asynchronous.
- I_KEY  input  4  raw push-buttons, asynchronous, active-low (0 = pressed).
- I_ReadEnable  input  1  one-cycle load request from the Memory stage.
- I_ReadAddr  input  16  load address.
- O_ReadData  output  DATA_WIDTH  registered read data.
- O_ReadValid  output  1  high exactly one cycle after an accepted I_ReadEnable.
- O_SWLevel  output  10  debounced switch levels (for local LED echo).
- O_KeyPressed  output  4  debounced pressed levels (1 = pressed).
- O_IRQ  output  1  key-event interrupt; exists only with IO_KEY_IRQ_EN.

Behaviour:
- Reset, asynchronous on I_RESET high:
  - SW synchronizers = 0; KEY synchronizers = 4'b1111 (released).
  - All debounce counters = 0; stable SW = 0; stable pressed = 0; sticky events = 0.
  - O_ReadData = 0, O_ReadValid = 0, O_IRQ = 0.
  - Reset asserted mid-read drops the pending O_ReadValid.
- Synchronization: each raw bit passes through a 2-flop synchronizer; no logic sits between the two flops.
- Debounce, per bit, one counter of width clog2(DEBOUNCE_CYCLES):
  - Sync output == stable value: counter <= 0.
  - Sync output differs and counter == DEBOUNCE_CYCLES-1: stable <= sync output, counter <= 0.
  - Sync output differs otherwise: counter increments.
  - Net effect: a change must persist for DEBOUNCE_CYCLES consecutive cycles at the sync output. Pin-to-stable latency is 2 + DEBOUNCE_CYCLES cycles.
  - Any shorter glitch is discarded and its counter restarts from 0.
- Key polarity: pressed = ~KEY, taken after synchronization and applied before debounce. Stable pressed drives O_KeyPressed.
- Event detect: a 0->1 transition of stable pressed[i] sets sticky[i] in the same edge where stable pressed updates.
- Read port, one request per cycle, no backpressure:
  - On an edge with I_ReadEnable = 1: O_ReadValid <= 1, O_ReadData <= selected value. Otherwise O_ReadValid <= 0 and O_ReadData holds its value.
  - ADDR_SW returns {zero-pad, stable SW[9:0]}.
  - ADDR_KEY returns {zero-pad, pressed[3:0]}.
  - ADDR_KEYEVT returns {zero-pad, sticky[3:0]}, and clears sticky at that same edge.
  - Any other address returns 0 with O_ReadValid still asserted and no side effects.
- Simultaneous event: if a new press event on bit i and a clear-on-read of ADDR_KEYEVT occur at the same edge:
  - The read returns the pre-edge sticky value.
  - sticky[i] ends set (set wins), so the event is not lost.
- Back-to-back ADDR_KEYEVT reads: the second read returns only events that arrived after the first read.

Optional Feature:
- Macro: IO_KEY_IRQ_EN.
- Defined:
  - O_IRQ is a registered OR of sticky[3:0]. It rises one cycle after the sticky bit sets and falls one cycle after the clearing read.
  - The SW debounce path is unchanged.
- Undefined: the O_IRQ port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: assert I_RESET with I_SW=10'h3FF, I_KEY=4'h0 -> O_SWLevel=0, O_KeyPressed=0, O_ReadValid=0 while reset is held. After release, O_SWLevel=10'h3FF exactly 2+16 cycles later.
2. Glitch reject: I_SW[0] pulses high for 15 cycles then returns low -> O_SWLevel[0] stays 0. A 16-cycle pulse -> O_SWLevel[0] rises on cycle 18 after the pin change.
3. Press event: drive I_KEY=4'b1101 steady. Then read ADDR_KEYEVT -> O_ReadValid=1 the next cycle with O_ReadData=16'h0002. An immediate re-read returns 16'h0000.
4. Set/clear collision: time the stable press of KEY[3] to update on the same edge as a read of ADDR_KEYEVT with sticky=4'b0001 -> the read returns 16'h0001, and the following read returns 16'h0008.
5. Address decode: read 16'hF010 with SW=10'h2A5 -> 16'h02A5. Read 16'hF020 with KEY[0] held -> 16'h0001. Read 16'h1234 -> 16'h0000 with valid=1, and sticky is unchanged.
6. IO_KEY_IRQ_EN: press KEY[2] -> O_IRQ=1 one cycle after sticky sets. Read ADDR_KEYEVT -> O_IRQ=0 one cycle after the read edge.

Source files
------------

// File: rtl/io_input_port.sv
// Memory-mapped input port: synchronizes and debounces SW/KEY, latches sticky key presses,
// and serves one-cycle-latency loads. Define IO_KEY_IRQ_EN to add the O_IRQ key-event output.
module io_input_port #(
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter int          DATA_WIDTH      = 16,
   parameter logic [15:0] ADDR_SW         = 16'hF010,
   parameter logic [15:0] ADDR_KEY        = 16'hF020,
   parameter logic [15:0] ADDR_KEYEVT     = 16'hF030
) (
   input  logic                  I_CLOCK,
   input  logic                  I_RESET,
   input  logic [9:0]            I_SW,
   input  logic [3:0]            I_KEY,
   input  logic                  I_ReadEnable,
   input  logic [15:0]           I_ReadAddr,
   output logic [DATA_WIDTH-1:0] O_ReadData,
   output logic                  O_ReadValid,
   output logic [9:0]            O_SWLevel,
   output logic [3:0]            O_KeyPressed
`ifdef IO_KEY_IRQ_EN
   ,
   output logic                  O_IRQ
`endif
);

   localparam int NB = 14;
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [9:0]            sw_meta_q, sw_sync_q;
   logic [3:0]            key_meta_q, key_sync_q;
   logic [NB-1:0]         db_in;
   logic [NB-1:0]         stable_q, stable_d;
   logic [CW-1:0]         cnt_q [NB];
   logic [CW-1:0]         cnt_d [NB];
   logic [3:0]            sticky_q, sticky_d;
   logic [3:0]            key_evt;
   logic                  evt_clr;
   logic [DATA_WIDTH-1:0] data_q, data_d, rd_sel;
   logic                  valid_q, valid_d;

   // Bits [13:10] carry pressed = ~KEY so both buses share one debounce array.
   assign db_in = {~key_sync_q, sw_sync_q};

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NB; i++) begin
         cnt_d[i] = '0;
         if (db_in[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = db_in[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      rd_sel = '0;
      case (I_ReadAddr)
         ADDR_SW:     rd_sel = DATA_WIDTH'(stable_q[9:0]);
         ADDR_KEY:    rd_sel = DATA_WIDTH'(stable_q[13:10]);
         ADDR_KEYEVT: rd_sel = DATA_WIDTH'(sticky_q);
         default:     rd_sel = '0;
      endcase
   end

   // A press landing on the clearing edge survives: set wins over clear.
   always_comb begin
      key_evt  = stable_d[13:10] & ~stable_q[13:10];
      evt_clr  = I_ReadEnable && (I_ReadAddr == ADDR_KEYEVT);
      sticky_d = (evt_clr ? 4'b0000 : sticky_q) | key_evt;
      valid_d  = I_ReadEnable;
      data_d   = I_ReadEnable ? rd_sel : data_q;
   end

   always_ff @(posedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         key_meta_q <= 4'b1111;
         key_sync_q <= 4'b1111;
         stable_q   <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
         sticky_q   <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         sw_meta_q  <= I_SW;
         sw_sync_q  <= sw_meta_q;
         key_meta_q <= I_KEY;
         key_sync_q <= key_meta_q;
         stable_q   <= stable_d;
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
         sticky_q   <= sticky_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

`ifdef IO_KEY_IRQ_EN
   logic irq_q, irq_d;

   always_comb irq_d = |sticky_q;

   always_ff @(posedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) irq_q <= 1'b0;
      else         irq_q <= irq_d;
   end

   assign O_IRQ = irq_q;
`endif

   assign O_ReadData   = data_q;
   assign O_ReadValid  = valid_q;
   assign O_SWLevel    = stable_q[9:0];
   assign O_KeyPressed = stable_q[13:10];

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port: debounce timing, sticky events, read decode and reset.
module tb_io_input_port;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  sw;
   logic [3:0]  key;
   logic        ren;
   logic [15:0] raddr;
   logic [15:0] rdata;
   logic        rvalid;
   logic [9:0]  sw_lvl;
   logic [3:0]  key_pr;
`ifdef IO_KEY_IRQ_EN
   logic        irq;
`endif

   int vectors = 0;
   int miscompares = 0;

   io_input_port dut (
      .I_CLOCK      (clk),
      .I_RESET      (rst),
      .I_SW         (sw),
      .I_KEY        (key),
      .I_ReadEnable (ren),
      .I_ReadAddr   (raddr),
      .O_ReadData   (rdata),
      .O_ReadValid  (rvalid),
      .O_SWLevel    (sw_lvl),
      .O_KeyPressed (key_pr)
`ifdef IO_KEY_IRQ_EN
      ,
      .O_IRQ        (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues a one-cycle load, then checks the registered response after that edge.
   task automatic read_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      ren   = 1'b1;
      raddr = addr;
      tick();
      ren   = 1'b0;
      check({tag, "_valid"}, {15'd0, rvalid}, 16'd1);
      check({tag, "_data"}, rdata, exp);
   endtask

   initial begin
      rst = 1'b1; sw = 10'h3FF; key = 4'h0; ren = 1'b0; raddr = 16'h0000;

      // Reset state while held, then 18-cycle pin-to-stable latency
      repeat (3) tick();
      check("rst_sw",    {6'd0, sw_lvl}, 16'h0000);
      check("rst_key",   {12'd0, key_pr}, 16'h0000);
      check("rst_valid", {15'd0, rvalid}, 16'h0000);
      check("rst_data",  rdata, 16'h0000);
      rst = 1'b0;
      repeat (17) tick();
      check("rel_sw_17", {6'd0, sw_lvl}, 16'h0000);
      tick();
      check("rel_sw_18",  {6'd0, sw_lvl}, 16'h03FF);
      check("rel_key_18", {12'd0, key_pr}, 16'h000F);

      rst = 1'b1; sw = 10'h000; key = 4'hF;
      repeat (2) tick();
      rst = 1'b0;
      check("rst2_sw", {6'd0, sw_lvl}, 16'h0000);

      // 15-cycle glitch is dropped
      sw = 10'h001;
      repeat (15) tick();
      sw = 10'h000;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("glitch15", {6'd0, sw_lvl}, 16'h0000);
      end

      // 16-cycle pulse is accepted on edge 18
      sw = 10'h001;
      repeat (16) tick();
      sw = 10'h000;
      tick();
      check("pulse16_e17", {6'd0, sw_lvl}, 16'h0000);
      tick();
      check("pulse16_e18", {6'd0, sw_lvl}, 16'h0001);
      repeat (20) tick();
      check("pulse16_fall", {6'd0, sw_lvl}, 16'h0000);
      check("idle_valid", {15'd0, rvalid}, 16'h0000);

      // Press KEY[1], clear-on-read, immediate re-read
      key = 4'b1101;
      repeat (17) tick();
      check("key1_e17", {12'd0, key_pr}, 16'h0000);
      tick();
      check("key1_e18", {12'd0, key_pr}, 16'h0002);
      read_chk("evt_first", 16'hF030, 16'h0002);
      read_chk("evt_reread", 16'hF030, 16'h0000);
      tick();
      check("valid_drop", {15'd0, rvalid}, 16'h0000);
      check("data_hold",  rdata, 16'h0000);

      // Set/clear collision: KEY[3] stabilizes on the same edge as the clearing read
      key = 4'b1100;
      repeat (20) tick();
      check("key0_held", {12'd0, key_pr}, 16'h0003);
      key = 4'b0100;
      repeat (17) tick();
      check("key3_e17", {12'd0, key_pr}, 16'h0003);
      read_chk("collide_rd", 16'hF030, 16'h0001);
      check("key3_e18", {12'd0, key_pr}, 16'h000B);
      read_chk("collide_next", 16'hF030, 16'h0008);

      // Address decode
      sw = 10'h2A5;
      repeat (20) tick();
      read_chk("rd_sw", 16'hF010, 16'h02A5);
      key = 4'b1110;
      repeat (20) tick();
      read_chk("rd_key", 16'hF020, 16'h0001);

      key = 4'b1010;
      repeat (18) tick();
`ifdef IO_KEY_IRQ_EN
      check("irq_at_set", {15'd0, irq}, 16'h0000);
      tick();
      check("irq_rise", {15'd0, irq}, 16'h0001);
`else
      tick();
`endif
      read_chk("rd_bad", 16'h1234, 16'h0000);
      read_chk("rd_evt_after_bad", 16'hF030, 16'h0004);
`ifdef IO_KEY_IRQ_EN
      check("irq_at_clr", {15'd0, irq}, 16'h0001);
      tick();
      check("irq_fall", {15'd0, irq}, 16'h0000);
`endif

      // Reset mid-read drops the pending valid
      ren = 1'b1; raddr = 16'hF010;
      tick();
      ren = 1'b0;
      check("pre_rst_valid", {15'd0, rvalid}, 16'h0001);
      rst = 1'b1;
      #1;
      check("midrd_valid", {15'd0, rvalid}, 16'h0000);
      check("midrd_data",  rdata, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
